port_remap: RTL and testbench
=============================

PORT_REMAP -- requirements
Module: port_remap

Interface
REQ-001 Parameter DATA_WIDTH, default 64, SHALL set the data bus width.
REQ-002 Parameter CTRL_WIDTH, default DATA_WIDTH/8, SHALL set the ctrl bus width.
REQ-003 Parameter NUM_PORTS, default 4, even, 2..8, SHALL set the MAC port count (MAC i = src code 2i, CPU i = 2i+1).
REQ-004 Parameter FIFO_DEPTH_BITS, default 3, SHALL set input FIFO depth 2^FIFO_DEPTH_BITS words.
REQ-005 Parameter IOQ_STAGE_NUM, default 8'hFF, SHALL set the ctrl value marking the IOQ module header.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 in_data/in_ctrl/in_wr  in  DATA_WIDTH/CTRL_WIDTH/1  upstream word, write strobe.
REQ-009 in_rdy  out  1  upstream may write next cycle.
REQ-010 out_data/out_ctrl/out_wr  out  DATA_WIDTH/CTRL_WIDTH/1  registered downstream word, write strobe.
REQ-011 out_rdy  in  1  downstream can accept a word.
REQ-012 mode  in  2  0 SWAP, 1 REFLECT, 2 TABLE, 3 DROP_ALL.
REQ-013 dst_table  in  16*NUM_PORTS  entry i = 16-bit one-hot dst mask for MAC i.
REQ-014 clear_counts  in  1  synchronous counter clear.
REQ-015 fwd_count/drop_count  out  32/32  packets forwarded/dropped.

Function
REQ-016 Input SHALL pass through a fallthrough FIFO; in_rdy = NOT nearly_full (one free slot remaining); writes when full are undefined upstream error.
REQ-017 A word SHALL be read from FIFO and registered to out_* in the same cycle only when FIFO non-empty and out_rdy=1, except in DROP states (no out_rdy needed); out_wr=1 for exactly that following cycle.
REQ-018 Minimum latency in_wr to out_wr SHALL be 2 cycles; sustained throughput 1 word/cycle.
REQ-019 States: IDLE, HDR, DATA, DROP_HDR, DROP_DATA.
REQ-020 IDLE, first word ctrl==IOQ_STAGE_NUM: decide route from src=data[31:16] and mode sampled this cycle; forward -> write modified word, go HDR; drop -> consume silently, go DROP_HDR.
REQ-021 IDLE, first word ctrl other nonzero: pass unmodified, count forwarded, go HDR; ctrl==0: pass unmodified, count forwarded, go DATA.
REQ-022 HDR: pass words; ctrl==0 -> DATA. DATA: pass words; ctrl!=0 (EOP) -> IDLE.
REQ-023 DROP_HDR: consume; ctrl==0 -> DROP_DATA. DROP_DATA: consume; ctrl!=0 -> IDLE.
REQ-024 Modification SHALL replace only data[63:48] (dst port) of the IOQ word; all other bits unchanged.
REQ-025 SWAP: MAC i -> dst = 1<<(2*(i XOR 1)); CPU or src>=2*NUM_PORTS -> drop.
REQ-026 REFLECT: src<2*NUM_PORTS -> dst = 1<<src; else drop.
REQ-027 TABLE: MAC i -> dst = dst_table[16i+15:16i], zero entry -> drop; CPU or out-of-range -> drop.
REQ-028 DROP_ALL: every IOQ-headed packet dropped.
REQ-029 mode and dst_table changes mid-packet SHALL NOT affect the packet in flight.
REQ-030 fwd_count/drop_count SHALL increment by 1 in the cycle the first word is consumed, wrap modulo 2^32.
REQ-031 clear_counts=1 SHALL zero both counters next edge, overriding a same-cycle increment.

Reset
REQ-032 reset=0 SHALL asynchronously force: state IDLE, FIFO empty, out_wr=0, out_data=0, out_ctrl=0, counters 0, in_rdy=1 within one cycle after release.
REQ-033 Reset mid-packet SHALL discard partial packet; first word after release is treated as packet start.

Verification
REQ-034 SWAP, IOQ src=2, 4-word packet, out_rdy=1 -> out dst field 16'h0001, other bits equal, out_wr 4 consecutive cycles, fwd_count=1.
REQ-035 TABLE, entry1=0, src=2 -> no out_wr, drop_count=1; same packet with entry1=16'h0040 -> dst 16'h0040.
REQ-036 REFLECT, src=5 -> dst 16'h0020; SWAP, src=5 -> dropped while out_rdy=0 held (FIFO drains).
REQ-037 out_rdy toggling 1/0 every cycle over 8-word packet -> no word lost/duplicated, order preserved, in_rdy deasserts at nearly_full.
REQ-038 mode changed SWAP->DROP_ALL during DATA -> current packet completes forwarded, next dropped; clear_counts coincident with increment -> counters 0.
REQ-039 reset asserted mid-packet -> out_wr=0 immediately, counters 0; next clean packet forwarded correctly.

Source files
------------

// File: rtl/port_remap.sv
// -----------------------------------------------------------------------------
// port_remap
//
// Rewrites the destination-port field of packets on a NetFPGA-style
// data/ctrl word stream. Each packet may start with an IOQ module header
// (ctrl == IOQ_STAGE_NUM). That header carries the source port in
// data[31:16] and the one-hot destination mask in data[63:48]. Depending on
// `mode`, the block computes a new destination mask or drops the whole packet.
// Packets that do not start with an IOQ header pass through unchanged.
//
// Data path: input fallthrough FIFO -> packet FSM -> registered output.
// The route is chosen once, while the first word sits at the FIFO head. Later
// changes to mode or dst_table therefore never affect a packet in flight.
//
// Ports
//   clk           sole clock, rising edge
//   reset         asynchronous, active-low reset
//   in_data       upstream data word                      [DATA_WIDTH]
//   in_ctrl       upstream ctrl word                      [CTRL_WIDTH]
//   in_wr         upstream write strobe
//   in_rdy        upstream may write in the next cycle
//   out_data      registered downstream data word         [DATA_WIDTH]
//   out_ctrl      registered downstream ctrl word         [CTRL_WIDTH]
//   out_wr        downstream write strobe (one per word)
//   out_rdy       downstream can accept a word
//   mode          0 SWAP, 1 REFLECT, 2 TABLE, 3 DROP_ALL
//   dst_table     entry i (bits 16i+15:16i) = one-hot dst mask for MAC i
//   clear_counts  synchronous clear of both packet counters
//   fwd_count     packets forwarded (wraps at 2^32)
//   drop_count    packets dropped   (wraps at 2^32)
//
// Source encoding: MAC i = 2i, CPU i = 2i+1. The destination field is
// data[63:48], so DATA_WIDTH must be at least 64.
// -----------------------------------------------------------------------------
module port_remap #(
  parameter int                    DATA_WIDTH      = 64,
  parameter int                    CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int                    NUM_PORTS       = 4,
  parameter int                    FIFO_DEPTH_BITS = 3,
  parameter logic [CTRL_WIDTH-1:0] IOQ_STAGE_NUM   = 8'hFF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic [CTRL_WIDTH-1:0]   in_ctrl,
  input  logic                    in_wr,
  output logic                    in_rdy,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic [CTRL_WIDTH-1:0]   out_ctrl,
  output logic                    out_wr,
  input  logic                    out_rdy,
  input  logic [1:0]              mode,
  input  logic [16*NUM_PORTS-1:0] dst_table,
  input  logic                    clear_counts,
  output logic [31:0]             fwd_count,
  output logic [31:0]             drop_count
);

  localparam int DEPTH  = 1 << FIFO_DEPTH_BITS;
  localparam int WORD_W = DATA_WIDTH + CTRL_WIDTH;
  localparam int CNT_W  = FIFO_DEPTH_BITS + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_DROP_HDR,
    S_DROP_DATA
  } state_t;

  typedef enum logic [1:0] {
    MODE_SWAP     = 2'd0,
    MODE_REFLECT  = 2'd1,
    MODE_TABLE    = 2'd2,
    MODE_DROP_ALL = 2'd3
  } mode_t;

  // ---------------------------------------------------------------------------
  // Input fallthrough FIFO
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0]          fifo_mem [DEPTH];
  logic [FIFO_DEPTH_BITS-1:0] wr_ptr;
  logic [FIFO_DEPTH_BITS-1:0] rd_ptr;
  logic [CNT_W-1:0]           fifo_count;
  logic                       fifo_empty;
  logic                       fifo_full;
  logic                       nearly_full;
  logic                       fifo_wr;
  logic                       fifo_rd;
  logic [WORD_W-1:0]          head_word;
  logic [DATA_WIDTH-1:0]      head_data;
  logic [CTRL_WIDTH-1:0]      head_ctrl;

  assign fifo_empty  = (fifo_count == '0);
  assign fifo_full   = (fifo_count == CNT_W'(DEPTH));
  // Keeping one slot spare gives upstream a full cycle to see in_rdy drop
  // without overrunning the FIFO.
  assign nearly_full = (fifo_count >= CNT_W'(DEPTH - 1));
  assign in_rdy      = !nearly_full;
  // A write while full is an upstream error. It is ignored so that the
  // pointers stay coherent.
  assign fifo_wr     = in_wr && !fifo_full;

  // Fallthrough: the head word is visible as soon as it is written.
  assign head_word = fifo_mem[rd_ptr];
  assign head_data = head_word[WORD_W-1:CTRL_WIDTH];
  assign head_ctrl = head_word[CTRL_WIDTH-1:0];

  // NOTE: the storage array is deliberately not reset. Its contents are
  // only observable through rd_ptr/fifo_count, and those are reset.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr] <= {in_data, in_ctrl};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({fifo_wr, fifo_rd})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Route decision for the IOQ header at the FIFO head
  // ---------------------------------------------------------------------------
  logic [15:0] src;
  logic        route_fwd;
  logic [15:0] route_dst;

  assign src = head_data[31:16];

  // NOTE: every signal driven here gets a default first, so no path through
  // the case/if tree can leave it unassigned and infer a latch.
  always_comb begin
    route_fwd = 1'b0;
    route_dst = '0;
    case (mode_t'(mode))
      MODE_SWAP: begin
        // MAC i is sent to its partner MAC (i XOR 1). CPU and out-of-range
        // sources match no port and fall through to drop.
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (src == 16'(2 * p)) begin
            route_fwd = 1'b1;
            route_dst = 16'(1) << (2 * (p ^ 1));
          end
        end
      end
      MODE_REFLECT: begin
        if (src < 16'(2 * NUM_PORTS)) begin
          route_fwd = 1'b1;
          route_dst = 16'(1) << src[3:0];
        end
      end
      MODE_TABLE: begin
        // An all-zero table entry means "no destination", which drops.
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (src == 16'(2 * p) && dst_table[16*p +: 16] != 16'h0000) begin
            route_fwd = 1'b1;
            route_dst = dst_table[16*p +: 16];
          end
        end
      end
      default: begin
        route_fwd = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Packet FSM
  // ---------------------------------------------------------------------------
  state_t                state;
  state_t                state_next;
  logic                  emit;
  logic [DATA_WIDTH-1:0] emit_data;
  logic                  fwd_inc;
  logic                  drop_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    fifo_rd    = 1'b0;
    emit       = 1'b0;
    emit_data  = head_data;
    fwd_inc    = 1'b0;
    drop_inc   = 1'b0;

    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          if (head_ctrl == IOQ_STAGE_NUM) begin
            if (route_fwd) begin
              if (out_rdy) begin
                fifo_rd          = 1'b1;
                emit             = 1'b1;
                emit_data[63:48] = route_dst;
                fwd_inc          = 1'b1;
                state_next       = S_HDR;
              end
            end else begin
              // A dropped packet produces no output, so it does not wait
              // for out_rdy.
              fifo_rd    = 1'b1;
              drop_inc   = 1'b1;
              state_next = S_DROP_HDR;
            end
          end else if (out_rdy) begin
            fifo_rd    = 1'b1;
            emit       = 1'b1;
            fwd_inc    = 1'b1;
            state_next = (head_ctrl == '0) ? S_DATA : S_HDR;
          end
        end
      end

      S_HDR: begin
        if (!fifo_empty && out_rdy) begin
          fifo_rd = 1'b1;
          emit    = 1'b1;
          if (head_ctrl == '0) state_next = S_DATA;
        end
      end

      S_DATA: begin
        if (!fifo_empty && out_rdy) begin
          fifo_rd = 1'b1;
          emit    = 1'b1;
          // A non-zero ctrl in the payload marks the last word (EOP).
          if (head_ctrl != '0) state_next = S_IDLE;
        end
      end

      S_DROP_HDR: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          if (head_ctrl == '0) state_next = S_DROP_DATA;
        end
      end

      S_DROP_DATA: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          if (head_ctrl != '0) state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registered output
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_wr   <= 1'b0;
      out_data <= '0;
      out_ctrl <= '0;
    end else begin
      out_wr <= emit;
      if (emit) begin
        out_data <= emit_data;
        out_ctrl <= head_ctrl;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Packet counters (clear wins over a same-cycle increment)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_count  <= '0;
      drop_count <= '0;
    end else if (clear_counts) begin
      fwd_count  <= '0;
      drop_count <= '0;
    end else begin
      if (fwd_inc)  fwd_count  <= fwd_count + 32'd1;
      if (drop_inc) drop_count <= drop_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_port_remap.sv
// -----------------------------------------------------------------------------
// tb_port_remap
//
// Directed testbench for port_remap. The stimulus pushes each expected output
// word into a queue as the word is issued. A negedge monitor pops the queue
// and compares every word the DUT writes. Counters and handshake signals are
// checked against hand-computed constants.
// -----------------------------------------------------------------------------
module tb_port_remap;

  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [63:0]   in_data = '0;
  logic [7:0]    in_ctrl = '0;
  logic          in_wr = 1'b0;
  logic          in_rdy;
  logic [63:0]   out_data;
  logic [7:0]    out_ctrl;
  logic          out_wr;
  logic          out_rdy = 1'b1;
  logic [1:0]    mode = 2'd0;
  logic [16*NP-1:0] dst_table = '0;
  logic          clear_counts = 1'b0;
  logic [31:0]   fwd_count;
  logic [31:0]   drop_count;

  port_remap dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_ctrl      (in_ctrl),
    .in_wr        (in_wr),
    .in_rdy       (in_rdy),
    .out_data     (out_data),
    .out_ctrl     (out_ctrl),
    .out_wr       (out_wr),
    .out_rdy      (out_rdy),
    .mode         (mode),
    .dst_table    (dst_table),
    .clear_counts (clear_counts),
    .fwd_count    (fwd_count),
    .drop_count   (drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          checks = 0;
  int          errors = 0;
  logic [71:0] exp_q [$];
  int          wr_times [$];
  logic [63:0] pkt_d [16];
  logic [7:0]  pkt_c [16];
  int          last_issue = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every DUT write must match the oldest expected word.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_wr === 1'b1) begin
      wr_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_wr actual=%h/%h expected=none", out_data, out_ctrl);
      end else begin
        check("out_word", {out_data, out_ctrl}, exp_q.pop_front());
      end
    end
  end

  // IOQ header + (n-2) data words (ctrl 0) + EOP word (ctrl 8'h01).
  task automatic build_pkt(input logic [15:0] src, input int n, input logic [15:0] tag);
    pkt_d[0] = {16'hDEAD, tag, src, 16'h5A5A};
    pkt_c[0] = 8'hFF;
    for (int i = 1; i < n; i++) begin
      pkt_d[i] = {tag, 16'(i), 16'hC0DE, 16'(i)};
      pkt_c[i] = (i == n - 1) ? 8'h01 : 8'h00;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the write edge.
  task automatic send_word(input logic [63:0] d, input logic [7:0] c);
    int w = 0;
    while (!in_rdy && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_rdy) begin
      checks++;
      errors++;
      $display("FAIL in_rdy_timeout actual=0 expected=1");
      return;
    end
    in_data = d;
    in_ctrl = c;
    in_wr = 1'b1;
    last_issue = cyc;
    @(posedge clk); #1;
    in_wr = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi, input bit fwd, input logic [15:0] dst);
    for (int i = lo; i <= hi; i++) begin
      if (fwd) exp_q.push_back(i == 0 ? {dst, pkt_d[0][47:0], pkt_c[0]} : {pkt_d[i], pkt_c[i]});
      send_word(pkt_d[i], pkt_c[i]);
    end
  endtask

  task automatic drain(input string name);
    int w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    check(name, 72'(exp_q.size()), 72'd0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hdr_issue;

    // ---------------- reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_wr", 72'(out_wr), 72'd0);
    check("rst_out_data", 72'(out_data), 72'd0);
    check("rst_out_ctrl", 72'(out_ctrl), 72'd0);
    check("rst_fwd", 72'(fwd_count), 72'd0);
    check("rst_drop", 72'(drop_count), 72'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("rst_in_rdy", 72'(in_rdy), 72'd1);

    // ---------------- SWAP, src=2 -> dst 0x0001, 4 back-to-back words
    mode = 2'd0;
    wr_times.delete();
    build_pkt(16'd2, 4, 16'h0004);
    send_range(0, 0, 1'b1, 16'h0001);
    hdr_issue = last_issue;
    send_range(1, 3, 1'b1, 16'h0001);
    drain("swap_drain");
    check("swap_wr_count", 72'(wr_times.size()), 72'd4);
    if (wr_times.size() == 4) begin
      check("swap_wr_consecutive", 72'(wr_times[3] - wr_times[0]), 72'd3);
      check("swap_latency", 72'(wr_times[0] - hdr_issue), 72'd2);
    end
    check("swap_fwd", 72'(fwd_count), 72'd1);

    // ---------------- TABLE, entry1 = 0 -> drop; then 0x0040 -> forward
    mode = 2'd2;
    dst_table = {16'h0008, 16'h0004, 16'h0000, 16'h0010};
    build_pkt(16'd2, 4, 16'h0100);
    send_range(0, 3, 1'b0, 16'h0000);
    drain("table_drop_drain");
    check("table_drop_count", 72'(drop_count), 72'd1);
    check("table_drop_fwd", 72'(fwd_count), 72'd1);
    dst_table = {16'h0008, 16'h0004, 16'h0040, 16'h0010};
    send_range(0, 3, 1'b1, 16'h0040);
    drain("table_fwd_drain");
    check("table_fwd", 72'(fwd_count), 72'd2);

    // ---------------- REFLECT src=5 -> 0x0020; SWAP src=5 dropped with out_rdy=0
    mode = 2'd1;
    build_pkt(16'd5, 4, 16'h0200);
    send_range(0, 3, 1'b1, 16'h0020);
    drain("reflect_drain");
    check("reflect_fwd", 72'(fwd_count), 72'd3);
    mode = 2'd0;
    out_rdy = 1'b0;
    build_pkt(16'd5, 10, 16'h0300);
    send_range(0, 9, 1'b0, 16'h0000);
    drain("swap_cpu_drain");
    check("swap_cpu_drop", 72'(drop_count), 72'd2);
    check("swap_cpu_in_rdy", 72'(in_rdy), 72'd1);

    // ---------------- out_rdy toggling over an 8-word packet (REFLECT src=0)
    mode = 2'd1;
    wr_times.delete();
    build_pkt(16'd0, 8, 16'h0400);
    send_range(0, 6, 1'b1, 16'h0001);
    check("nearly_full_in_rdy", 72'(in_rdy), 72'd0);
    fork
      send_range(7, 7, 1'b1, 16'h0001);
      begin
        repeat (30) begin
          out_rdy = ~out_rdy;
          @(posedge clk); #1;
        end
        out_rdy = 1'b1;
      end
    join
    drain("toggle_drain");
    check("toggle_wr_count", 72'(wr_times.size()), 72'd8);
    check("toggle_fwd", 72'(fwd_count), 72'd4);

    // ---------------- mode SWAP -> DROP_ALL mid-packet
    mode = 2'd0;
    build_pkt(16'd4, 6, 16'h0500);
    send_range(0, 2, 1'b1, 16'h0040);
    repeat (3) @(posedge clk);
    #1;
    mode = 2'd3;
    send_range(3, 5, 1'b1, 16'h0040);
    drain("modechg_a_drain");
    send_range(0, 5, 1'b0, 16'h0000);
    repeat (12) @(posedge clk);
    #1;
    check("modechg_fwd", 72'(fwd_count), 72'd5);
    check("modechg_drop", 72'(drop_count), 72'd3);

    // clear_counts in the same cycle as a forward increment
    exp_q.push_back({64'h1111_2222_3333_4444, 8'h00});
    exp_q.push_back({64'h5555_6666_7777_8888, 8'h02});
    send_word(64'h1111_2222_3333_4444, 8'h00);
    clear_counts = 1'b1;
    @(posedge clk); #1;
    clear_counts = 1'b0;
    send_word(64'h5555_6666_7777_8888, 8'h02);
    drain("clear_drain");
    check("clear_fwd", 72'(fwd_count), 72'd0);
    check("clear_drop", 72'(drop_count), 72'd0);

    // ---------------- reset mid-packet, then a clean packet
    mode = 2'd0;
    build_pkt(16'd2, 4, 16'h0600);
    send_range(0, 1, 1'b1, 16'h0001);
    @(negedge clk); #1;
    check("pre_reset_fwd", 72'(fwd_count), 72'd1);
    reset = 1'b0;
    #1;
    check("midrst_out_wr", 72'(out_wr), 72'd0);
    check("midrst_fwd", 72'(fwd_count), 72'd0);
    check("midrst_in_rdy", 72'(in_rdy), 72'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    build_pkt(16'd6, 4, 16'h0700);
    send_range(0, 3, 1'b1, 16'h0010);
    drain("post_reset_drain");
    check("post_reset_fwd", 72'(fwd_count), 72'd1);
    check("post_reset_drop", 72'(drop_count), 72'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
